delayer_fsm: RTL and testbench

DELAYER_FSM -- requirements
Module: delayer_fsm

---
 rtl/delayer_pkg.sv | 18 +
 rtl/delayer_fsm_if.sv | 21 ++
 rtl/delay_counter.sv | 37 +++
 rtl/delayer_fsm.sv | 92 +++++++++
 tb/tb_delayer_fsm.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/delayer_pkg.sv
// Shared types and constants for the delayer block.
// Holds the FSM state enum and the default window latency.
package delayer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned LATENCY_DEF = 8;
  localparam int unsigned LATENCY_MAX = 255;

  function automatic bit lat_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/delayer_fsm_if.sv
// Requester <-> delayer handshake bundle.
// stall/delay driven by the requester (master), stop by the delayer (slave).
interface delayer_fsm_if;

  logic stall;
  logic delay;
  logic stop;

  modport master (
    output stall,
    output delay,
    input  stop
  );

  modport slave (
    input  stall,
    input  delay,
    output stop
  );

endinterface

// File: rtl/delay_counter.sv
// Loadable down-counter that saturates at zero.
// Ports: clk, reset (async active-low), load_i/load_val_i, en_i, zero_o.
module delay_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins over enable; never steps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/delayer_fsm.sv
// Holds stop high for LATENCY unstalled cycles after an accepted delay.
// Ports: clk, reset (async active-low), bus (stall, delay -> stop).
// Define DELAYER_TRACE_EN for a per-edge simulation trace line.
import delayer_pkg::*;

module delayer_fsm #(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  delayer_fsm_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  if (!lat_ok(LATENCY)) begin : g_bad_latency
    $error("delayer_fsm: LATENCY must be 1..255");
  end

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_e state_q;
  state_e state_d;
  logic   cnt_load;
  logic   cnt_en;
  logic   cnt_zero;

  delay_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.delay && !bus.stall) begin
          cnt_load = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // delay is ignored here: no queueing
        if (!bus.stall) begin
          if (cnt_zero) begin
            state_d = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DONE: begin
        // one dead cycle so the requester can update
        if (!bus.stall) begin
          state_d = IDLE;
        end
      end
      default: begin
        // stray encodings recover even under stall
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.stop = (state_q == BUSY);

`ifdef DELAYER_TRACE_EN
  always @(posedge clk) begin
    $display("%0t st=%s cnt=%0d delay=%b stall=%b stop=%b",
             $time, state_q.name(), u_cnt.cnt_q,
             bus.delay, bus.stall, bus.stop);
  end
`else
`endif

endmodule

// File: tb/tb_delayer_fsm.sv
// Self-checking bench: LATENCY=8 and LATENCY=1 instances, directed + random.
// Reference model counts remaining window cycles and the re-arm gap.
module tb_delayer_fsm;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   left8, gap8, left1, gap1;
  int   hi8, hi1;

  delayer_fsm_if bus8 ();
  delayer_fsm_if bus1 ();

  delayer_fsm #(.LATENCY(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  delayer_fsm #(.LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one unstalled edge: burn a window cycle, else the dead cycle,
  // else accept a request
  task automatic upd(inout int left, inout int gap,
                     input int lat, input logic d, input logic s);
    if (s) return;
    if (left > 0) begin
      left = left - 1;
      if (left == 0) gap = 1;
    end else if (gap > 0) begin
      gap = gap - 1;
    end else if (d) begin
      left = lat;
    end
  endtask

  task automatic chk(input string tag);
    total++;
    assert (bus8.stop === (left8 > 0)) else begin
      bad++;
      $error("FAIL %s.stop8 got=%b exp=%b", tag, bus8.stop, left8 > 0);
    end
    total++;
    assert (bus1.stop === (left1 > 0)) else begin
      bad++;
      $error("FAIL %s.stop1 got=%b exp=%b", tag, bus1.stop, left1 > 0);
    end
    if (bus8.stop === 1'b1) hi8++;
    if (bus1.stop === 1'b1) hi1++;
  endtask

  task automatic drive(input logic d, input logic s);
    bus8.delay = d;
    bus8.stall = s;
    bus1.delay = d;
    bus1.stall = s;
  endtask

  task automatic step(input logic d, input logic s, input string tag);
    drive(d, s);
    @(posedge clk);
    upd(left8, gap8, 8, d, s);
    upd(left1, gap1, 1, d, s);
    @(negedge clk);
    chk(tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "drain");
  endtask

  task automatic cnt_chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    left8 = 0;
    gap8  = 0;
    left1 = 0;
    gap1  = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mdl_reset();
    drive(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("reset");
    @(negedge clk);
    chk("reset_hold");
    reset = 1'b1;

    // single pulse
    hi8 = 0;
    hi1 = 0;
    step(1'b1, 1'b0, "pulse");
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, "pulse");
    cnt_chk("pulse_len8", hi8, 8);
    cnt_chk("pulse_len1", hi1, 1);
    drain();

    // stall 3 cycles mid-window
    hi8 = 0;
    step(1'b1, 1'b0, "stall");
    step(1'b0, 1'b0, "stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "stall");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "stall");
    cnt_chk("stall_len8", hi8, 11);
    drain();

    // delay held: 8 high, 2 low repeating
    hi8 = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, "held");
    cnt_chk("held_len8", hi8, 24);
    drain();

    // reset mid-window
    step(1'b1, 1'b0, "rst");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "rst");
    #2;
    reset = 1'b0;
    mdl_reset();
    #1;
    chk("rst_async");
    @(negedge clk);
    reset = 1'b1;
    hi8 = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "rst_after");
    cnt_chk("rst_after_len8", hi8, 0);

    // latency 1: pulse during DONE ignored
    hi1 = 0;
    step(1'b1, 1'b0, "l1");
    step(1'b0, 1'b0, "l1");
    step(1'b1, 1'b0, "l1_done");
    step(1'b0, 1'b0, "l1");
    step(1'b0, 1'b0, "l1");
    cnt_chk("l1_len", hi1, 1);
    drain();

    // request under stall, then release
    hi8 = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "idle_stall");
    step(1'b1, 1'b0, "idle_go");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "idle_go");
    cnt_chk("idle_go_len8", hi8, 8);
    drain();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
